dmem_responder: RTL and testbench

Multi-cycle data-memory responder for the MIPS data port. It receives the processor's memory requests: `mem_read`, `mem_write`, `data_addr` and `write_data`. It serves each request from an internal word array after a programmable latency. It drives `read_data`, a one-cycle `ready` pulse and a `stall` signal that freezes the processor's PC while an access is in flight. It replaces the zero-wait-state data memory when the team models slow memory behind the single-cycle core.

---
 rtl/dmem_responder.sv | 97 +++++++++
 tb/tb_dmem_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MIPS data port: serves each load/store
// from an internal word array after LATENCY wait cycles, stalling the core meanwhile.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting; a request is latched on the edge ending this cycle
// BUSY  | latency down-counter running; commit when cnt reaches zero
// DONE  | ready pulse for one cycle, then back to IDLE
module dmem_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                state, state_nx;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           wdata;
  logic                  op_wr;
  logic [31:0]           mem [2**ADDR_WIDTH];

  logic req, accept, commit;
  logic unused_addr_bits;

  assign req    = mem_read | mem_write;
  assign accept = (state == IDLE) && req;
  assign commit = (state == BUSY) && (cnt == 4'd0);

  // Byte offset and bits above the array size are don't-care: accesses alias.
  assign unused_addr_bits = ^{data_addr[31:ADDR_WIDTH+2], data_addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) state_nx = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd0) state_nx = DONE;
      end
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      idx       <= '0;
      wdata     <= 32'h0;
      op_wr     <= 1'b0;
      read_data <= 32'h0;
    end else begin
      if (accept) begin
        cnt   <= CNT_LOAD;
        idx   <= data_addr[ADDR_WIDTH+1:2];
        wdata <= write_data;
        op_wr <= mem_write;
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !op_wr) read_data <= mem[idx];
    end
  end

  // The array has no reset; an aborted access never reaches commit because
  // reset forces the state back to IDLE asynchronously.
  always_ff @(posedge clk) begin
    if (commit && op_wr) mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table of accesses on a LATENCY=2 instance
// with a read-data scoreboard, plus hand sequences for reset and LATENCY=1 corners.
module tb_dmem_responder;

  logic        clk, reset;
  logic        mem_read, mem_write;
  logic [31:0] data_addr, write_data, read_data;
  logic        ready, stall;

  logic        f_mem_read, f_mem_write;
  logic [31:0] f_data_addr, f_write_data, f_read_data;
  logic        f_ready, f_stall;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        chk;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        chk;
  } vec_t;
  vec_t vecs[11];

  dmem_responder #(.ADDR_WIDTH(6), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .data_addr(data_addr), .write_data(write_data), .read_data(read_data),
    .ready(ready), .stall(stall)
  );

  dmem_responder #(.ADDR_WIDTH(6), .LATENCY(1)) dut_fast (
    .clk(clk), .reset(reset), .mem_read(f_mem_read), .mem_write(f_mem_write),
    .data_addr(f_data_addr), .write_data(f_write_data), .read_data(f_read_data),
    .ready(f_ready), .stall(f_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: every ready pulse of the LATENCY=2 instance must match a queued access.
  always @(negedge clk) begin
    #2;
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", {31'h0, ready}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk) check("read_data", read_data, e.rdata);
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp, input logic chk);
    int  stalls = 0;
    logic seen  = 1'b0;
    sb.push_back('{exp, chk});
    @(negedge clk);
    mem_read = rd; mem_write = wr; data_addr = addr; write_data = wd;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ready === 1'b1) begin
        seen = 1'b1;
        check("stall_in_done", {31'h0, stall}, 32'h0);
        break;
      end
      if (stall === 1'b1) stalls++;
      @(negedge clk);
    end
    check("ready_seen", {31'h0, seen}, 32'h1);
    check("stall_cycles", 32'(stalls), 32'd3);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0104, 32'h0000_1234, 32'hDEADBEEF, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,        32'h0000_1234, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0007, 32'h0,        32'h0000_1234, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0030, 32'h0000_0055, 32'h0000_1234, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0030, 32'h0,        32'h0000_0055, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hA5A5A5A5, 32'h0000_0055, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        32'hA5A5A5A5, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0000_0001, 32'hA5A5A5A5, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,        32'h0000_0001, 1'b1};

    reset = 1'b1;
    mem_read = 1'b1; mem_write = 1'b0; data_addr = 32'h3C; write_data = 32'h0;
    f_mem_read = 1'b0; f_mem_write = 1'b0; f_data_addr = 32'h0; f_write_data = 32'h0;

    // Reset held with a load pending, then released.
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_ready", {31'h0, ready}, 32'h0);
      check("rst_read_data", read_data, 32'h0);
      check("rst_stall", {31'h0, stall}, 32'h1);
    end
    sb.push_back('{32'h0, 1'b0});
    reset = 1'b0;
    k = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      if (ready === 1'b1) begin k = c; break; end
      check("post_rst_stall", {31'h0, stall}, 32'h1);
    end
    check("post_rst_ready_cycle", 32'(k), 32'd3);
    mem_read = 1'b0;

    for (int i = 0; i < 11; i++)
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].exp, vecs[i].chk);

    // Write to 0x08 aborted by reset in its second BUSY cycle.
    @(negedge clk);
    mem_write = 1'b1; data_addr = 32'h08; write_data = 32'h0000_FFFF;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; mem_write = 1'b0;
    #1 check("abort_ready", {31'h0, ready}, 32'h0);
    @(negedge clk); #1;
    check("abort_ready_held", {31'h0, ready}, 32'h0);
    check("abort_read_data", read_data, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    access(1'b1, 1'b0, 32'h08, 32'h0, 32'h0000_0001, 1'b1);

    // LATENCY=1 instance, load held across two accesses.
    @(negedge clk);
    f_mem_read = 1'b1; f_data_addr = 32'h0;
    for (int c = 0; c <= 6; c++) begin
      logic exp_rdy;
      if (c > 0) @(negedge clk);
      #1;
      exp_rdy = (c == 2) || (c == 5);
      check($sformatf("fast_ready_c%0d", c), {31'h0, f_ready}, {31'h0, exp_rdy});
      check($sformatf("fast_stall_c%0d", c), {31'h0, f_stall}, {31'h0, ~exp_rdy});
    end
    f_mem_read = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
